// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: owner tags, access sizes and request payload shared by the arbiter and its bench
package sram_bus_pkg;
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/owner_fifo.sv
// owner_fifo: in-order 1-bit owner tags for transactions accepted but not yet answered
module owner_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign head = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like slave between IF and MEM masters, routing responses back in order
module sram_bus_arbiter
  import sram_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        slv_req,
  output logic        slv_wr,
  output logic [1:0]  slv_size,
  output logic [3:0]  slv_wstrb,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  input  logic        slv_addr_ok,
  input  logic        slv_data_ok,
  input  logic [31:0] slv_rdata,
  output logic        idle,
  output logic        resp_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(DEPTH + 1);
  req_t inst_p, data_p, slv_p;
  logic grant_inst, grant_data, accept, pop, head, full, empty, starved;
  logic resp_err_q, resp_err_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [CW-1:0] count;
  assign inst_p = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_p = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  assign starved = starve_q == SW'(STARVE_LIMIT);
  // full comes from the registered count only, keeping slv_data_ok off the slv_req path
  always_comb begin
    grant_data = !reset && !full && data_req && !(inst_req && starved);
    grant_inst = !reset && !full && !grant_data && inst_req;
    slv_p = grant_data ? data_p : grant_inst ? inst_p : '0;
    accept = (grant_data || grant_inst) && slv_addr_ok;
    pop = slv_data_ok && !empty;
    resp_err_d = resp_err_q || (slv_data_ok && empty);
    starve_d = (!inst_req || (grant_inst && slv_addr_ok)) ? '0 :
               (!grant_inst && !starved) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_err_q <= 1'b0;
      starve_q <= '0;
    end else begin
      resp_err_q <= resp_err_d;
      starve_q <= starve_d;
    end
  end
  owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .din   (grant_data ? OWNER_DATA : OWNER_INST),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  assign slv_req = grant_data || grant_inst;
  assign slv_wr = slv_p.wr;
  assign slv_size = slv_p.size;
  assign slv_wstrb = slv_p.wstrb;
  assign slv_addr = slv_p.addr;
  assign slv_wdata = slv_p.wdata;
  assign inst_addr_ok = grant_inst && slv_addr_ok;
  assign data_addr_ok = grant_data && slv_addr_ok;
  assign inst_data_ok = pop && head == OWNER_INST;
  assign data_data_ok = pop && head == OWNER_DATA;
  assign inst_rdata = slv_rdata;
  assign data_rdata = slv_rdata;
  assign idle = count == '0;
  assign resp_err = resp_err_q;
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one sram-like slave port between the instruction-fetch master (IF) and the data master (MEM stage load/store).
- Sits between the pipeline and the bridge/memory.
- Arbitrates the address phase with data-priority plus anti-starvation.
- Tracks outstanding transactions in order and routes each data_ok/rdata response back to its issuing master.

Parameters:
- DEPTH, 2, maximum outstanding transactions (owner FIFO depth, power of two, ≥1).
- STARVE_LIMIT, 8, consecutive cycles a pending inst request may be denied before it is force-granted.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- inst_req  in  1  IF request valid
- inst_wr  in  1  IF write (normally 0)
- inst_size  in  2  IF size (0=byte,1=half,2=word)
- inst_wstrb  in  4  IF byte strobes
- inst_addr  in  32  IF address
- inst_wdata  in  32  IF write data
- inst_addr_ok  out  1  IF address phase accepted
- inst_data_ok  out  1  IF response valid
- inst_rdata  out  32  IF read data
- data_req  in  1  MEM request valid
- data_wr  in  1  MEM write
- data_size  in  2  MEM size
- data_wstrb  in  4  MEM byte strobes
- data_addr  in  32  MEM address
- data_wdata  in  32  MEM write data
- data_addr_ok  out  1  MEM address phase accepted
- data_data_ok  out  1  MEM response valid
- data_rdata  out  32  MEM read data
- slv_req  out  1  slave request valid
- slv_wr  out  1  slave write
- slv_size  out  2  slave size
- slv_wstrb  out  4  slave strobes
- slv_addr  out  32  slave address
- slv_wdata  out  32  slave write data
- slv_addr_ok  in  1  slave accepted address phase
- slv_data_ok  in  1  slave response valid (in issue order)
- slv_rdata  in  32  slave read data
- idle  out  1  no outstanding transactions (FIFO empty)
- resp_err  out  1  sticky: slv_data_ok seen with FIFO empty

Behaviour:
- State:
  - owner FIFO: DEPTH entries × 1 bit (0=inst, 1=data).
  - count: 0..DEPTH.
  - starve_cnt: width clog2(STARVE_LIMIT+1).
  - resp_err flag.
  - All clear asynchronously on reset.
  - Outputs during/after reset: slv_req=0, all *_addr_ok=0, all *_data_ok=0, idle=1, resp_err=0.
- full = (count==DEPTH), taken from the registered count.
  - Push is blocked when full even if a pop occurs in the same cycle, so there is no comb path from slv_data_ok to slv_req.
- Grant (combinational):
  - If full: no grant.
  - Else if data_req and !(inst_req && starve_cnt==STARVE_LIMIT): grant data.
  - Else if inst_req: grant inst.
  - Else: none.
- slv_req = granted master's req.
- slv_wr/size/wstrb/addr/wdata mux from the granted master; they are 0 when no grant.
- Only the granted master sees addr_ok: inst_addr_ok = grant_inst & slv_addr_ok, and likewise for data.
- Handshake:
  - Address accepted when slv_req & slv_addr_ok, giving zero-latency addr_ok.
  - On acceptance, push the owner bit.
  - Masters must hold req and payload stable until addr_ok; the arbiter does not latch payload.
- Grant may switch between cycles while the slave stalls (slv_addr_ok=0). This is legal because the slave samples only on acceptance.
- starve_cnt:
  - Reset to 0 when an inst request is accepted or inst_req=0.
  - Otherwise, if inst_req && grant!=inst, increment, saturating at STARVE_LIMIT.
- Response routing:
  - On slv_data_ok with count>0: pop the head; inst_data_ok = slv_data_ok & head==0, data_data_ok = slv_data_ok & head==1.
  - slv_rdata is passed unmasked to both rdata outputs; a master qualifies it with its data_ok.
  - Responses return in acceptance order.
- Simultaneous push and pop (not full): count unchanged; the push writes the tail while the head advances.
- Same-cycle accept and response with count==0: the response is an error (slave must not respond before the address is accepted). Set resp_err, route no data_ok, still push the new entry.
- Pointers wrap modulo DEPTH.
- Reset mid-transaction drops all outstanding owners; any later slv_data_ok sets resp_err.
- Latency: arbitration 0 cycles; response routing 0 cycles (purely combinational from slv_data_ok and the FIFO head).

Decomposition:
- Package sram_bus_pkg:
  - constants OWNER_INST=1'b0, OWNER_DATA=1'b1;
  - SIZE_BYTE/HALF/WORD = 2'd0/1/2;
  - request-payload struct (wr, size, wstrb, addr, wdata).
- One sub-module, owner_fifo: 1-bit-wide, DEPTH-deep, synchronous push/pop, async reset. Outputs head, count, full, empty.

Test Plan:
- Both req high at t0, slv_addr_ok=1, count=0 -> data_addr_ok=1, inst_addr_ok=0, slv_addr=data_addr; next cycle inst accepted (count reaches 2 with DEPTH=2).
- Continuous data_req with inst_req held for 8 denied cycles (STARVE_LIMIT=8) -> cycle 9 grants inst (slv_addr=inst_addr), starve_cnt returns to 0.
- Accept inst@0x1C000000 then data@0x00001000, then slv_data_ok twice with rdata 0xAAAA5555 and 0x12345678 -> inst_data_ok on the first, data_data_ok on the second, rdata matches.
- DEPTH=2 full, data_req high, slv_data_ok same cycle -> slv_req=0 that cycle, data request accepted the next cycle, idle=0 throughout.
- slv_data_ok with idle=1 -> resp_err=1 and stays 1; no *_data_ok. Async reset mid-stream -> idle=1, resp_err=0 immediately.
